// File: rtl/pre_stage_arbiter.sv
// Round-robin arbiter sharing one pre_stage_unit between two vector sources.
// Grants last for a whole vector of SUB_VECTOR_NO beats, and the source tag is delayed to line up with the unit output.
module pre_stage_arbiter #(
   parameter int BUS_WIDTH     = 128,
   parameter int SUB_VECTOR_NO = 2,
   parameter int UNIT_LATENCY  = 3,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BUS_WIDTH-1:0] s0_tdata,
   input  logic                 s0_tvalid,
   output logic                 s0_tready,
   input  logic [BUS_WIDTH-1:0] s1_tdata,
   input  logic                 s1_tvalid,
   output logic                 s1_tready,
   output logic [BUS_WIDTH-1:0] o_Vector,
   output logic                 o_Valid,
   output logic                 o_Tag,
   output logic                 o_LastSub,
   output logic                 o_UnitTag,
   output logic                 o_UnitTagValid,
   output logic [CNT_WIDTH-1:0] o_VecCnt0,
   output logic [CNT_WIDTH-1:0] o_VecCnt1
);

   localparam int SW = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1;

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

   state_t                state, state_nx;
   logic [SW-1:0]         sub_idx, sub_idx_nx;
   logic                  rr, rr_nx;
   logic                  sel, hs, last;
   logic [UNIT_LATENCY-1:0] tag_pipe, vld_pipe;

   assign s0_tready      = (state == GRANT0);
   assign s1_tready      = (state == GRANT1);
   assign o_UnitTag      = tag_pipe[UNIT_LATENCY-1];
   assign o_UnitTagValid = vld_pipe[UNIT_LATENCY-1];

   always_comb begin
      sel        = (state == GRANT1);
      hs         = ((state == GRANT0) && s0_tvalid) || ((state == GRANT1) && s1_tvalid);
      last       = (sub_idx == SW'(SUB_VECTOR_NO - 1));
      state_nx   = state;
      sub_idx_nx = sub_idx;
      rr_nx      = rr;
      case (state)
         IDLE: begin
            if (s0_tvalid && s1_tvalid) state_nx = rr ? GRANT1 : GRANT0;
            else if (s0_tvalid)         state_nx = GRANT0;
            else if (s1_tvalid)         state_nx = GRANT1;
         end
         default: begin
            if (hs) begin
               if (last) begin
                  // Vector boundary: hand priority to the other channel and
                  // switch without a bubble if it is already waiting.
                  sub_idx_nx = '0;
                  rr_nx      = ~sel;
                  if (sel ? s0_tvalid : s1_tvalid)      state_nx = sel ? GRANT0 : GRANT1;
                  else if (sel ? s1_tvalid : s0_tvalid) state_nx = state;
                  else                                  state_nx = IDLE;
               end else begin
                  sub_idx_nx = sub_idx + SW'(1);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sub_idx   <= '0;
         rr        <= 1'b0;
         o_Vector  <= '0;
         o_Valid   <= 1'b0;
         o_Tag     <= 1'b0;
         o_LastSub <= 1'b0;
         o_VecCnt0 <= '0;
         o_VecCnt1 <= '0;
      end else begin
         state   <= state_nx;
         sub_idx <= sub_idx_nx;
         rr      <= rr_nx;
         o_Valid <= hs;
         if (hs) begin
            o_Vector  <= sel ? s1_tdata : s0_tdata;
            o_Tag     <= sel;
            o_LastSub <= last;
            if (last) begin
               if (sel) o_VecCnt1 <= o_VecCnt1 + CNT_WIDTH'(1);
               else     o_VecCnt0 <= o_VecCnt0 + CNT_WIDTH'(1);
            end
         end
      end
   end

   if (UNIT_LATENCY > 1) begin : g_pipe
      always_ff @(posedge clk) begin
         if (rst) begin
            tag_pipe <= '0;
            vld_pipe <= '0;
         end else begin
            tag_pipe <= {tag_pipe[UNIT_LATENCY-2:0], o_Tag};
            vld_pipe <= {vld_pipe[UNIT_LATENCY-2:0], o_Valid & o_LastSub};
         end
      end
   end else begin : g_pipe1
      always_ff @(posedge clk) begin
         if (rst) begin
            tag_pipe <= '0;
            vld_pipe <= '0;
         end else begin
            tag_pipe <= o_Tag;
            vld_pipe <= o_Valid & o_LastSub;
         end
      end
   end

endmodule

// File: tb/tb_pre_stage_arbiter.sv
// Directed bench for pre_stage_arbiter: scripted beat sources, output log, hand-computed expectations.
// A second instance with a 2-bit counter shares the stimulus to exercise counter wrap.
module tb_pre_stage_arbiter;

   localparam int BW = 128;

   logic          clk = 1'b0;
   logic          rst;
   logic [BW-1:0] s0_tdata, s1_tdata;
   logic          s0_tvalid, s1_tvalid, s0_tready, s1_tready;
   logic [BW-1:0] o_Vector;
   logic          o_Valid, o_Tag, o_LastSub, o_UnitTag, o_UnitTagValid;
   logic [15:0]   o_VecCnt0, o_VecCnt1;

   logic          u2_s0_tready, u2_s1_tready;
   logic [BW-1:0] u2_Vector;
   logic          u2_Valid, u2_Tag, u2_LastSub, u2_UnitTag, u2_UnitTagValid;
   logic [1:0]    u2_VecCnt0, u2_VecCnt1;

   always #5 clk = ~clk;

   pre_stage_arbiter dut (
      .clk(clk), .rst(rst),
      .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
      .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
      .o_Vector(o_Vector), .o_Valid(o_Valid), .o_Tag(o_Tag), .o_LastSub(o_LastSub),
      .o_UnitTag(o_UnitTag), .o_UnitTagValid(o_UnitTagValid),
      .o_VecCnt0(o_VecCnt0), .o_VecCnt1(o_VecCnt1)
   );

   pre_stage_arbiter #(.CNT_WIDTH(2)) dut_w2 (
      .clk(clk), .rst(rst),
      .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(u2_s0_tready),
      .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(u2_s1_tready),
      .o_Vector(u2_Vector), .o_Valid(u2_Valid), .o_Tag(u2_Tag), .o_LastSub(u2_LastSub),
      .o_UnitTag(u2_UnitTag), .o_UnitTagValid(u2_UnitTagValid),
      .o_VecCnt0(u2_VecCnt0), .o_VecCnt1(u2_VecCnt1)
   );

   logic [BW-1:0] q0[$], q1[$];
   int            p0, p1, cyc;
   bit            en0, en1;

   int            lg_cyc[$];
   bit            lg_tag[$], lg_last[$];
   logic [BW-1:0] lg_data[$];
   int            utv_cyc[$];
   bit            utv_tag[$];
   logic [1:0]    lg_cnt2[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive();
      s0_tvalid = en0 && (p0 < q0.size());
      s0_tdata  = (p0 < q0.size()) ? q0[p0] : '0;
      s1_tvalid = en1 && (p1 < q1.size());
      s1_tdata  = (p1 < q1.size()) ? q1[p1] : '0;
   endtask

   // Samples handshakes and outputs mid-cycle, then advances the sources after the edge.
   task automatic tick();
      bit h0, h1;
      @(negedge clk);
      h0 = s0_tvalid && s0_tready;
      h1 = s1_tvalid && s1_tready;
      if (o_Valid) begin
         lg_cyc.push_back(cyc);
         lg_tag.push_back(o_Tag);
         lg_last.push_back(o_LastSub);
         lg_data.push_back(o_Vector);
      end
      if (u2_Valid && u2_LastSub) lg_cnt2.push_back(u2_VecCnt0);
      if (o_UnitTagValid) begin
         utv_cyc.push_back(cyc);
         utv_tag.push_back(o_UnitTag);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (h0) p0++;
      if (h1) p1++;
      drive();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      en0 = 1'b0; en1 = 1'b0;
      q0.delete(); q1.delete();
      p0 = 0; p1 = 0;
      drive();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      lg_cyc.delete(); lg_tag.delete(); lg_last.delete(); lg_data.delete();
      utv_cyc.delete(); utv_tag.delete(); lg_cnt2.delete();
   endtask

   initial begin
      logic [BW-1:0] a, b, e;
      int k;
      cyc = 0;
      rst = 1'b1;
      en0 = 1'b0; en1 = 1'b0; p0 = 0; p1 = 0;
      drive();
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Reset state
      chk("rst_valid", o_Valid, 0);
      chk("rst_cnt0", o_VecCnt0, 0);
      chk("rst_cnt1", o_VecCnt1, 0);
      chk("rst_ready0", s0_tready, 0);
      chk("rst_ready1", s1_tready, 0);
      chk("rst_utv", o_UnitTagValid, 0);
      chk("rst_vector", o_Vector, 0);

      // Test 1: single ch0 vector
      a = {32{4'h1}};
      b = 128'hFFFFFFFF00000000FFFFFFFF00000000;
      q0.push_back(a); q0.push_back(b);
      en0 = 1'b1; drive();
      ticks(10);
      chk("t1_nbeats", lg_data.size(), 2);
      if (lg_data.size() >= 2) begin
         chk("t1_data0", lg_data[0], a);
         chk("t1_data1", lg_data[1], b);
         chk("t1_tag0", lg_tag[0], 0);
         chk("t1_tag1", lg_tag[1], 0);
         chk("t1_last0", lg_last[0], 0);
         chk("t1_last1", lg_last[1], 1);
         chk("t1_consec", lg_cyc[1] - lg_cyc[0], 1);
      end
      chk("t1_cnt0", o_VecCnt0, 1);
      chk("t1_cnt1", o_VecCnt1, 0);
      chk("t1_nutv", utv_cyc.size(), 1);
      if (utv_cyc.size() >= 1 && lg_cyc.size() >= 2) begin
         chk("t1_utv_delay", utv_cyc[0] - lg_cyc[1], 3);
         chk("t1_utag", utv_tag[0], 0);
      end

      // Test 2: both channels saturated, 4 vectors each
      do_reset();
      for (int i = 0; i < 8; i++) begin
         q0.push_back({96'h0, 32'hA000_0000 + 32'(i)});
         q1.push_back({96'h0, 32'hB000_0000 + 32'(i)});
      end
      en0 = 1'b1; en1 = 1'b1; drive();
      ticks(25);
      chk("t2_nbeats", lg_data.size(), 16);
      for (int i = 0; i < 16 && i < lg_data.size(); i++) begin
         k = (i / 4) * 2 + (i % 2);
         e = ((i / 2) % 2) ? {96'h0, 32'hB000_0000 + 32'(k)} : {96'h0, 32'hA000_0000 + 32'(k)};
         chk($sformatf("t2_tag%0d", i), lg_tag[i], (i / 2) % 2);
         chk($sformatf("t2_last%0d", i), lg_last[i], i % 2);
         chk($sformatf("t2_data%0d", i), lg_data[i], e);
         chk($sformatf("t2_cyc%0d", i), lg_cyc[i] - lg_cyc[0], i);
      end
      chk("t2_cnt0", o_VecCnt0, 4);
      chk("t2_cnt1", o_VecCnt1, 4);
      chk("t2_nutv", utv_tag.size(), 8);
      for (int i = 0; i < 8 && i < utv_tag.size(); i++)
         chk($sformatf("t2_utag%0d", i), utv_tag[i], i % 2);

      // Test 3: ch1 stalls mid-vector while ch0 waits
      do_reset();
      q1.push_back(128'hC0); q1.push_back(128'hC1);
      q0.push_back(128'hD0); q0.push_back(128'hD1);
      en1 = 1'b1; drive();
      ticks(2);
      en1 = 1'b0; en0 = 1'b1; drive();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("t3_ready0_%0d", i), s0_tready, 0);
         chk($sformatf("t3_ready1_%0d", i), s1_tready, 1);
      end
      en1 = 1'b1; drive();
      ticks(8);
      chk("t3_nbeats", lg_data.size(), 4);
      if (lg_data.size() >= 4) begin
         chk("t3_data0", lg_data[0], 128'hC0);
         chk("t3_data1", lg_data[1], 128'hC1);
         chk("t3_data2", lg_data[2], 128'hD0);
         chk("t3_data3", lg_data[3], 128'hD1);
         chk("t3_gap", lg_cyc[1] - lg_cyc[0], 4);
         chk("t3_nobubble", lg_cyc[2] - lg_cyc[1], 1);
         chk("t3_tag1", lg_tag[1], 1);
         chk("t3_tag2", lg_tag[2], 0);
      end
      chk("t3_cnt0", o_VecCnt0, 1);
      chk("t3_cnt1", o_VecCnt1, 1);

      // Test 4: ch1 alone, 3 vectors back-to-back
      do_reset();
      for (int i = 0; i < 6; i++) q1.push_back(128'hE0 + 128'(i));
      en1 = 1'b1; drive();
      ticks(12);
      chk("t4_nbeats", lg_data.size(), 6);
      for (int i = 0; i < 6 && i < lg_data.size(); i++) begin
         chk($sformatf("t4_tag%0d", i), lg_tag[i], 1);
         chk($sformatf("t4_last%0d", i), lg_last[i], i % 2);
         chk($sformatf("t4_cyc%0d", i), lg_cyc[i] - lg_cyc[0], i);
      end
      chk("t4_cnt1", o_VecCnt1, 3);
      chk("t4_cnt0", o_VecCnt0, 0);

      // Test 5: reset mid-vector, then restart with both channels valid
      do_reset();
      q0.push_back(128'hF0); q0.push_back(128'hF1);
      en0 = 1'b1; drive();
      ticks(2);
      chk("t5_pre_valid", o_Valid, 1);
      do_reset();
      chk("t5_rst_valid", o_Valid, 0);
      chk("t5_rst_vector", o_Vector, 0);
      chk("t5_rst_cnt0", o_VecCnt0, 0);
      chk("t5_rst_ready0", s0_tready, 0);
      q0.push_back(128'h1F0); q0.push_back(128'h1F1);
      q1.push_back(128'h2A0); q1.push_back(128'h2A1);
      en0 = 1'b1; en1 = 1'b1; drive();
      ticks(8);
      chk("t5_nbeats", lg_data.size(), 4);
      if (lg_data.size() >= 4) begin
         chk("t5_tag0", lg_tag[0], 0);
         chk("t5_data0", lg_data[0], 128'h1F0);
         chk("t5_last0", lg_last[0], 0);
         chk("t5_last1", lg_last[1], 1);
         chk("t5_data1", lg_data[1], 128'h1F1);
         chk("t5_tag2", lg_tag[2], 1);
      end
      chk("t5_cnt0", o_VecCnt0, 1);
      chk("t5_cnt1", o_VecCnt1, 1);

      // Test 6: 2-bit counter wraps after 4 vectors
      do_reset();
      for (int i = 0; i < 10; i++) q0.push_back(128'h300 + 128'(i));
      en0 = 1'b1; drive();
      ticks(16);
      chk("t6_nvec", lg_cnt2.size(), 5);
      if (lg_cnt2.size() >= 5) begin
         chk("t6_cnt_a", lg_cnt2[0], 1);
         chk("t6_cnt_b", lg_cnt2[1], 2);
         chk("t6_cnt_c", lg_cnt2[2], 3);
         chk("t6_cnt_d", lg_cnt2[3], 0);
         chk("t6_cnt_e", lg_cnt2[4], 1);
      end
      chk("t6_cnt16", o_VecCnt0, 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
